mem_lsu: RTL and testbench

Parametrised load/store unit that replaces the pass-through MEM stage. Sits between ex_mem and mem_wb. Drives a req/gnt/rvalid memory bus with byte-lane alignment, strobe generation and sign extension, and stalls the pipeline until the access completes. Also detects misaligned and illegal accesses, and bounds bus latency with a timeout.

---
 rtl/mem_lsu.sv | 174 +++++++++++++++++
 tb/tb_mem_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - Load/store unit for the MEM stage on a req/gnt/rvalid bus
//
// Replaces the pass-through MEM stage. Non-memory instructions flow through
// combinationally. Loads and stores drive one bus transaction and stall the
// pipeline until it completes. Misaligned or illegal accesses never reach the bus.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   valid_i .. wdata_i MEM-stage access request (load/store, size code, address, data)
//   inst_addr_i/o, rd_waddr_i/o, rd_wdata_i/o, reg_wen_i/o   writeback pass-through
//   stall_o            hold the pipeline while an access is in flight
//   misalign_o         one-cycle pulse for a misaligned access
//   access_fault_o     one-cycle pulse for an illegal code, bus error or timeout
//   bus_*              memory bus: req/gnt handshake, rvalid/rdata/err response
module mem_lsu #(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                ren_i,
  input  logic                wen_i,
  input  logic [2:0]          funct3_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [63:0]         inst_addr_i,
  input  logic [4:0]          rd_waddr_i,
  input  logic [XLEN-1:0]     rd_wdata_i,
  input  logic                reg_wen_i,
  output logic [63:0]         inst_addr_o,
  output logic [4:0]          rd_waddr_o,
  output logic [XLEN-1:0]     rd_wdata_o,
  output logic                reg_wen_o,
  output logic                stall_o,
  output logic                misalign_o,
  output logic                access_fault_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [XLEN-1:0]     bus_wdata_o,
  output logic [XLEN/8-1:0]   bus_wstrb_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [XLEN-1:0]     bus_rdata_i,
  input  logic                bus_err_i
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_FAULT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rdata_q;
  logic            fault_mis;   // the pending FAULT is a misalignment, not an access fault
  logic            busy;

  logic            access, illegal, misaligned, timeout_hit;
  logic [2:0]      off;
  logic [5:0]      shamt;
  logic [3:0]      size_b;
  logic [15:0]     strb_full;
  logic [XLEN-1:0] lane, load_fmt;

  assign access = valid_i & (ren_i | wen_i);
  assign off    = 3'(addr_i[OFFW-1:0]);
  assign shamt  = {off, 3'b000};
  assign size_b = 4'd1 << funct3_i[1:0];

  assign illegal = (funct3_i == 3'b111) | (ren_i & wen_i) |
                   ((XLEN == 32) && (funct3_i == 3'b011 || funct3_i == 3'b110));

  always_comb begin
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  end

  // Disabled (TIMEOUT_CYC = 0) means WAIT is unbounded.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1));

  assign strb_full = ((16'd1 << size_b) - 16'd1) << off;

  // Load formatting works on the word latched in WAIT, since rdata is only valid there.
  assign lane = rdata_q >> shamt;
  always_comb begin
    load_fmt = lane;
    case (funct3_i)
      3'b000:  load_fmt = XLEN'($signed(lane[7:0]));
      3'b001:  load_fmt = XLEN'($signed(lane[15:0]));
      3'b010:  load_fmt = XLEN'($signed(lane[31:0]));
      3'b100:  load_fmt = XLEN'(lane[7:0]);
      3'b101:  load_fmt = XLEN'(lane[15:0]);
      3'b110:  load_fmt = XLEN'(lane[31:0]);
      default: load_fmt = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      fault_mis <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_WAIT) cnt <= cnt + CW'(1);
      else                 cnt <= '0;
      if (state == S_WAIT && bus_rvalid_i) rdata_q <= bus_rdata_i;
      // Only IDLE can route a misalignment to FAULT; later faults see it cleared.
      if (state == S_IDLE) fault_mis <= misaligned & ~illegal;
    end
  end

  always_comb begin
    state_n        = state;
    busy           = 1'b0;
    bus_req_o      = 1'b0;
    misalign_o     = 1'b0;
    access_fault_o = 1'b0;
    reg_wen_o      = reg_wen_i;
    rd_wdata_o     = rd_wdata_i;
    case (state)
      S_IDLE: begin
        if (access) begin
          busy    = 1'b1;
          state_n = (illegal | misaligned) ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        busy      = 1'b1;
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_n = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (bus_rvalid_i)     state_n = bus_err_i ? S_FAULT : S_RESP;
        else if (timeout_hit) state_n = S_FAULT;
      end
      S_RESP: begin
        if (ren_i) rd_wdata_o = load_fmt;
        state_n = S_IDLE;
      end
      S_FAULT: begin
        misalign_o     = fault_mis;
        access_fault_o = ~fault_mis;
        reg_wen_o      = 1'b0;
        state_n        = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Reset forces stall low even while upstream still presents an access.
  assign stall_o = busy & ~rst;

  // Bus payload is only driven while requesting so the bus idles at zero.
  assign bus_we_o    = bus_req_o & wen_i;
  assign bus_addr_o  = bus_req_o ? {addr_i[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
  assign bus_wdata_o = bus_req_o ? (wdata_i << shamt) : '0;
  assign bus_wstrb_o = bus_req_o ? strb_full[NB-1:0] : '0;

  assign inst_addr_o = inst_addr_i;
  assign rd_waddr_o  = rd_waddr_i;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - Directed self-checking bench for mem_lsu
module tb_mem_lsu;
  localparam int XLEN = 64;
  localparam int ADDR_W = 64;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_i, ren_i, wen_i, reg_wen_i, reg_wen_o, stall_o, misalign_o, access_fault_o;
  logic [2:0] funct3_i;
  logic [ADDR_W-1:0] addr_i, bus_addr_o;
  logic [XLEN-1:0] wdata_i, rd_wdata_i, rd_wdata_o, bus_wdata_o, bus_rdata_i;
  logic [63:0] inst_addr_i, inst_addr_o;
  logic [4:0] rd_waddr_i, rd_waddr_o;
  logic bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [XLEN/8-1:0] bus_wstrb_o;

  int errors = 0;
  int checks = 0;

  int o_stall, o_req, o_mis, o_flt;
  logic o_done, o_wen, o_we, o_unstable;
  logic [63:0] o_rd, o_addr, o_wdata;
  logic [7:0] o_strb;

  mem_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ren_i(ren_i), .wen_i(wen_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .inst_addr_i(inst_addr_i),
    .rd_waddr_i(rd_waddr_i), .rd_wdata_i(rd_wdata_i), .reg_wen_i(reg_wen_i),
    .inst_addr_o(inst_addr_o), .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o),
    .reg_wen_o(reg_wen_o), .stall_o(stall_o), .misalign_o(misalign_o),
    .access_fault_o(access_fault_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    valid_i = 0; ren_i = 0; wen_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_err_i = 0;
  endtask

  // Drives one access and acts as the bus slave; gnt after gnt_dly extra REQ
  // cycles, rvalid after rv_dly extra WAIT cycles (negative = never).
  task automatic do_access(input logic r, input logic w, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd, input int gnt_dly,
                           input int rv_dly, input logic [63:0] rd, input logic e);
    int wait_idx;
    logic granted;
    o_stall = 0; o_req = 0; o_mis = 0; o_flt = 0; o_done = 0; o_unstable = 0;
    o_rd = 0; o_wen = 0; o_we = 0; o_addr = 0; o_wdata = 0; o_strb = 0;
    granted = 0; wait_idx = 0;
    @(negedge clk);
    valid_i = 1; ren_i = r; wen_i = w; funct3_i = f3; addr_i = a; wdata_i = wd;
    for (int cyc = 0; cyc < 40 && !o_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus_gnt_i = 0; bus_rvalid_i = 0; bus_err_i = 0;
      #1;
      if (misalign_o) o_mis++;
      if (access_fault_o) o_flt++;
      if (bus_req_o) begin
        if (o_req == 0) begin
          o_addr = bus_addr_o; o_we = bus_we_o; o_wdata = bus_wdata_o; o_strb = bus_wstrb_o;
        end else if (bus_addr_o !== o_addr || bus_we_o !== o_we ||
                     bus_wdata_o !== o_wdata || bus_wstrb_o !== o_strb) begin
          o_unstable = 1;
        end
        if (o_req == gnt_dly) begin bus_gnt_i = 1; granted = 1; end
        o_req++;
      end else if (granted && stall_o) begin
        if (wait_idx == rv_dly) begin bus_rvalid_i = 1; bus_rdata_i = rd; bus_err_i = e; end
        wait_idx++;
      end
      if (stall_o) o_stall++;
      else begin o_done = 1; o_rd = rd_wdata_o; o_wen = reg_wen_o; end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    if (misalign_o) o_mis++;
    if (access_fault_o) o_flt++;
    if (bus_req_o) o_req++;
    checks++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL access_done: stall never dropped within 40 cycles"); end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus_req_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    checks++; if ({misalign_o, access_fault_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {misalign_o, access_fault_o}); end
    checks++; if ({bus_addr_o, bus_wdata_o, bus_wstrb_o, bus_we_o} !== '0) begin errors++; $display("FAIL reset_bus: bus outputs not zero"); end
    valid_i = 1; ren_i = 1; funct3_i = 3'b011; addr_i = 64'h1000; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_access: got %b want 0", stall_o); end
    @(negedge clk);
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    valid_i = 1; ren_i = 0; wen_i = 0; addr_i = 64'h1003; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b want 0", stall_o); end
    checks++; if (rd_wdata_o !== 64'hCAFE) begin errors++; $display("FAIL pass_rdata: got %h want cafe", rd_wdata_o); end
    checks++; if ({inst_addr_o, rd_waddr_o, reg_wen_o} !== {64'h4000, 5'd7, 1'b1}) begin errors++; $display("FAIL pass_fields: got %h %h %b", inst_addr_o, rd_waddr_o, reg_wen_o); end
    valid_i = 0; ren_i = 1; #1;
    checks++; if ({stall_o, bus_req_o} !== 2'b00) begin errors++; $display("FAIL pass_invalid: got %b want 00", {stall_o, bus_req_o}); end
    idle_inputs();
  endtask

  task automatic test_load_byte();
    do_access(1, 0, 3'b000, 64'h8000_0003, 0, 0, 0, 64'h0000_0000_8000_0000, 0);
    checks++; if (o_addr !== 64'h8000_0000) begin errors++; $display("FAIL lb_addr: got %h want 80000000", o_addr); end
    checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b want 0", o_we); end
    checks++; if (o_rd !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffffffffffff80", o_rd); end
    checks++; if (o_stall !== 3) begin errors++; $display("FAIL lb_stall: got %0d want 3", o_stall); end
    checks++; if (o_wen !== 1'b1) begin errors++; $display("FAIL lb_wen: got %b want 1", o_wen); end
  endtask

  task automatic test_load_formats();
    do_access(1, 0, 3'b101, 64'h1006, 0, 0, 0, 64'h8001_0000_0000_0000, 0);
    checks++; if (o_rd !== 64'h8001) begin errors++; $display("FAIL lhu_data: got %h want 8001", o_rd); end
    do_access(1, 0, 3'b010, 64'h1004, 0, 0, 1, 64'h8765_4321_0000_0000, 0);
    checks++; if (o_rd !== 64'hFFFF_FFFF_8765_4321) begin errors++; $display("FAIL lw_data: got %h want ffffffff87654321", o_rd); end
    checks++; if (o_stall !== 4) begin errors++; $display("FAIL lw_stall: got %0d want 4", o_stall); end
    do_access(1, 0, 3'b110, 64'h1004, 0, 0, 0, 64'h8765_4321_0000_0000, 0);
    checks++; if (o_rd !== 64'h8765_4321) begin errors++; $display("FAIL lwu_data: got %h want 87654321", o_rd); end
    do_access(1, 0, 3'b001, 64'h1002, 0, 0, 0, 64'h0000_0000_F00D_0000, 0);
    checks++; if (o_rd !== 64'hFFFF_FFFF_FFFF_F00D) begin errors++; $display("FAIL lh_data: got %h want fffffffffffff00d", o_rd); end
  endtask

  task automatic test_store();
    do_access(0, 1, 3'b001, 64'h1006, 64'hBEEF, 4, 0, 0, 0);
    checks++; if (o_strb !== 8'hC0) begin errors++; $display("FAIL sh_strb: got %h want c0", o_strb); end
    checks++; if (o_wdata !== 64'hBEEF_0000_0000_0000) begin errors++; $display("FAIL sh_wdata: got %h want beef000000000000", o_wdata); end
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b want 1", o_we); end
    checks++; if (o_addr !== 64'h1000) begin errors++; $display("FAIL sh_addr: got %h want 1000", o_addr); end
    checks++; if (o_req !== 5) begin errors++; $display("FAIL sh_req_cycles: got %0d want 5", o_req); end
    checks++; if (o_unstable !== 1'b0) begin errors++; $display("FAIL sh_stable: request fields changed before gnt"); end
    checks++; if (o_stall !== 7) begin errors++; $display("FAIL sh_stall: got %0d want 7", o_stall); end
    checks++; if (o_rd !== 64'hCAFE) begin errors++; $display("FAIL sh_rdata: got %h want cafe", o_rd); end
    do_access(0, 1, 3'b000, 64'h1005, 64'h5A, 0, 0, 0, 0);
    checks++; if ({o_strb, o_wdata} !== {8'h20, 64'h0000_5A00_0000_0000}) begin errors++; $display("FAIL sb_lane: got %h %h want 20 00005a0000000000", o_strb, o_wdata); end
    do_access(0, 1, 3'b011, 64'h1008, 64'h1122_3344_5566_7788, 0, 0, 0, 0);
    checks++; if ({o_strb, o_wdata, o_addr} !== {8'hFF, 64'h1122_3344_5566_7788, 64'h1008}) begin errors++; $display("FAIL sd_lane: got %h %h %h", o_strb, o_wdata, o_addr); end
  endtask

  task automatic test_misalign();
    do_access(1, 0, 3'b010, 64'h1002, 0, 0, 0, 0, 0);
    checks++; if (o_mis !== 1) begin errors++; $display("FAIL mis_pulse: got %0d cycles want 1", o_mis); end
    checks++; if (o_flt !== 0) begin errors++; $display("FAIL mis_fault: got %0d want 0", o_flt); end
    checks++; if (o_req !== 0) begin errors++; $display("FAIL mis_req: got %0d want 0", o_req); end
    checks++; if (o_stall !== 1) begin errors++; $display("FAIL mis_stall: got %0d want 1", o_stall); end
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL mis_wen: got %b want 0", o_wen); end
  endtask

  task automatic test_faults();
    do_access(1, 0, 3'b101, 64'h1000, 0, 0, 0, 64'hFFFF, 1);
    checks++; if ({o_flt, o_mis} !== {32'd1, 32'd0}) begin errors++; $display("FAIL err_pulse: got flt=%0d mis=%0d want 1 0", o_flt, o_mis); end
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL err_wen: got %b want 0", o_wen); end
    checks++; if (o_stall !== 3) begin errors++; $display("FAIL err_stall: got %0d want 3", o_stall); end
    do_access(1, 0, 3'b111, 64'h1003, 0, 0, 0, 0, 0);
    checks++; if ({o_flt, o_mis, o_req} !== {32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL f3_111: got flt=%0d mis=%0d req=%0d want 1 0 0", o_flt, o_mis, o_req); end
    checks++; if (o_stall !== 1) begin errors++; $display("FAIL f3_111_stall: got %0d want 1", o_stall); end
    do_access(1, 1, 3'b011, 64'h1000, 0, 0, 0, 0, 0);
    checks++; if ({o_flt, o_req} !== {32'd1, 32'd0}) begin errors++; $display("FAIL ren_wen: got flt=%0d req=%0d want 1 0", o_flt, o_req); end
  endtask

  task automatic test_timeout();
    do_access(1, 0, 3'b011, 64'h1000, 0, 0, -1, 0, 0);
    checks++; if (o_flt !== 1) begin errors++; $display("FAIL to_pulse: got %0d want 1", o_flt); end
    checks++; if (o_stall !== 10) begin errors++; $display("FAIL to_stall: got %0d want 10", o_stall); end
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL to_wen: got %b want 0", o_wen); end
    do_access(1, 0, 3'b011, 64'h1000, 0, 0, 6, 64'h0BAD_F00D_1234_5678, 0);
    checks++; if ({o_flt, o_stall} !== {32'd0, 32'd9}) begin errors++; $display("FAIL to_near: got flt=%0d stall=%0d want 0 9", o_flt, o_stall); end
    checks++; if (o_rd !== 64'h0BAD_F00D_1234_5678) begin errors++; $display("FAIL to_near_data: got %h", o_rd); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    valid_i = 1; ren_i = 1; funct3_i = 3'b011; addr_i = 64'h3000;
    @(negedge clk);
    bus_gnt_i = 1; #1;
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", bus_req_o); end
    @(negedge clk);
    bus_gnt_i = 0; #1;
    checks++; if ({stall_o, bus_req_o} !== 2'b10) begin errors++; $display("FAIL rst_pre_wait: got %b want 10", {stall_o, bus_req_o}); end
    rst = 1; #1;
    checks++; if ({stall_o, bus_req_o} !== 2'b00) begin errors++; $display("FAIL rst_mid: got %b want 00", {stall_o, bus_req_o}); end
    @(negedge clk);
    rst = 0; valid_i = 0; bus_rvalid_i = 1; bus_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD; #1;
    checks++; if ({stall_o, bus_req_o, access_fault_o} !== 3'b000) begin errors++; $display("FAIL rst_late_rvalid: got %b want 000", {stall_o, bus_req_o, access_fault_o}); end
    @(negedge clk);
    idle_inputs(); #1;
    checks++; if ({stall_o, bus_req_o, access_fault_o, misalign_o} !== 4'b0000) begin errors++; $display("FAIL rst_idle: got %b want 0000", {stall_o, bus_req_o, access_fault_o, misalign_o}); end
    do_access(1, 0, 3'b011, 64'h2000, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 0);
    checks++; if (o_rd !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rst_ld_data: got %h want 0123456789abcdef", o_rd); end
    checks++; if ({o_stall, o_flt} !== {32'd3, 32'd0}) begin errors++; $display("FAIL rst_ld_stall: got stall=%0d flt=%0d want 3 0", o_stall, o_flt); end
  endtask

  initial begin
    idle_inputs();
    inst_addr_i = 64'h4000; rd_waddr_i = 5'd7; rd_wdata_i = 64'hCAFE; reg_wen_i = 1'b1;
    test_reset();
    test_passthrough();
    test_load_byte();
    test_load_formats();
    test_store();
    test_misalign();
    test_faults();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
